// File: rtl/hdmi_text_pkg.sv
// Shared timing/text constants, control-register layout and byte-lane merge helper
// for the hdmi_text_controller slice.
package hdmi_text_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned HS_START = 656;
    localparam int unsigned HS_END   = 751;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_TOTAL  = 525;
    localparam int unsigned VS_START = 490;
    localparam int unsigned VS_END   = 491;

    localparam int unsigned COLS       = 80;
    localparam int unsigned ROWS       = 30;
    localparam int unsigned VRAM_WORDS = 600;
    localparam int unsigned CTRL_IDX   = 600;
    localparam int unsigned VRAM_AW    = 10;

    typedef struct packed {
        logic [6:0] rsvd_hi;
        logic [3:0] fg_r;
        logic [3:0] fg_g;
        logic [3:0] fg_b;
        logic [3:0] bg_r;
        logic [3:0] bg_g;
        logic [3:0] bg_b;
        logic       rsvd_lo;
    } ctrl_reg_t;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_val;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_val[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/hdmi_text_font_rom.sv
// 2048x8 combinational glyph ROM, address = {code[6:0], row[3:0]}, MSB = leftmost pixel.
// Glyphs use the IBM VGA 8x16 bitmaps; codes without an entry render blank.
module hdmi_text_font_rom
    import hdmi_text_pkg::*;
(
    input  logic [10:0] addr,
    output logic [7:0]  data
);

    logic [127:0] glyph;
    logic [3:0]   row;

    assign row = addr[3:0];

    always_comb begin
        glyph = '0;
        case (addr[10:4])
            7'h41: glyph = 128'h0000_1038_6cc6_c6fe_c6c6_c6c6_0000_0000; // A
            7'h42: glyph = 128'h0000_fc66_6666_7c66_6666_66fc_0000_0000; // B
            7'h43: glyph = 128'h0000_3c66_c2c0_c0c0_c0c2_663c_0000_0000; // C
            7'h44: glyph = 128'h0000_f86c_6666_6666_6666_6cf8_0000_0000; // D
            7'h45: glyph = 128'h0000_fe66_6268_7868_6062_66fe_0000_0000; // E
            7'h46: glyph = 128'h0000_fe66_6268_7868_6060_60f0_0000_0000; // F
            7'h48: glyph = 128'h0000_c6c6_c6c6_fec6_c6c6_c6c6_0000_0000; // H
            7'h49: glyph = 128'h0000_3c18_1818_1818_1818_183c_0000_0000; // I
            7'h4c: glyph = 128'h0000_f060_6060_6060_6062_66fe_0000_0000; // L
            7'h4f: glyph = 128'h0000_7cc6_c6c6_c6c6_c6c6_c67c_0000_0000; // O
            7'h54: glyph = 128'h0000_7e7e_5a18_1818_1818_183c_0000_0000; // T
            default: glyph = '0;
        endcase
    end

    assign data = glyph[127 - 8*row -: 8];

endmodule

// File: rtl/hdmi_text_controller.sv
// AXI4-Lite text-mode VRAM (80x30) with 640x480@60 timing and 8x16 font rendering.
// Optional debug taps (draw_x/draw_y/pixel_clk_en) enabled by defining HDMI_TEXT_DEBUG_EN.
module hdmi_text_controller
    import hdmi_text_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 16
) (
    input  logic                          axi_aclk,
    input  logic                          axi_aresetn,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic [2:0]                    axi_awprot,
    input  logic                          axi_awvalid,
    output logic                          axi_awready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                          axi_wvalid,
    output logic                          axi_wready,
    output logic [1:0]                    axi_bresp,
    output logic                          axi_bvalid,
    input  logic                          axi_bready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_araddr,
    input  logic [2:0]                    axi_arprot,
    input  logic                          axi_arvalid,
    output logic                          axi_arready,
    output logic [C_AXI_DATA_WIDTH-1:0]   axi_rdata,
    output logic [1:0]                    axi_rresp,
    output logic                          axi_rvalid,
    input  logic                          axi_rready,
    output logic [3:0]                    red,
    output logic [3:0]                    green,
    output logic [3:0]                    blue,
    output logic                          hsync,
    output logic                          vsync,
`ifdef HDMI_TEXT_DEBUG_EN
    output logic [9:0]                    draw_x,
    output logic [9:0]                    draw_y,
    output logic                          pixel_clk_en,
`endif
    output logic                          vde
);

    localparam int IW = C_AXI_ADDR_WIDTH - 2;

    logic [31:0]   vram [0:VRAM_WORDS-1];
    ctrl_reg_t     ctrl;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx_q;
    logic          wr_fire;
    logic          rd_fire;
    logic [31:0]   reg_rd;

    logic unused_ok;
    assign unused_ok = ^{axi_awprot, axi_arprot, axi_awaddr[1:0], axi_araddr[1:0]};

    assign wr_idx  = axi_awaddr[C_AXI_ADDR_WIDTH-1:2];
    assign wr_fire = axi_awvalid && axi_wvalid && !axi_bvalid && !axi_awready;
    assign rd_fire = axi_arvalid && !axi_rvalid && !axi_arready;

    assign axi_bresp = 2'b00;
    assign axi_rresp = 2'b00;

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            for (int unsigned i = 0; i < VRAM_WORDS; i++) vram[VRAM_AW'(i)] <= '0;
            ctrl <= '0;
        end else if (wr_fire) begin
            if (wr_idx < IW'(VRAM_WORDS))
                vram[wr_idx[VRAM_AW-1:0]] <= apply_wstrb(vram[wr_idx[VRAM_AW-1:0]], axi_wdata, axi_wstrb);
            else if (wr_idx == IW'(CTRL_IDX))
                ctrl <= ctrl_reg_t'(apply_wstrb(ctrl, axi_wdata, axi_wstrb));
        end
    end

    // Write is committed on the edge that raises awready; bvalid follows one cycle later.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            axi_awready <= 1'b0;
            axi_wready  <= 1'b0;
            axi_bvalid  <= 1'b0;
        end else begin
            axi_awready <= wr_fire;
            axi_wready  <= wr_fire;
            if (axi_awready)     axi_bvalid <= 1'b1;
            else if (axi_bready) axi_bvalid <= 1'b0;
        end
    end

    always_comb begin
        reg_rd = '0;
        if (rd_idx_q < IW'(VRAM_WORDS))   reg_rd = vram[rd_idx_q[VRAM_AW-1:0]];
        else if (rd_idx_q == IW'(CTRL_IDX)) reg_rd = ctrl;
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            axi_arready <= 1'b0;
            axi_rvalid  <= 1'b0;
            axi_rdata   <= '0;
            rd_idx_q    <= '0;
        end else begin
            axi_arready <= rd_fire;
            if (rd_fire) rd_idx_q <= axi_araddr[C_AXI_ADDR_WIDTH-1:2];
            if (axi_arready) begin
                axi_rvalid <= 1'b1;
                axi_rdata  <= reg_rd;
            end else if (axi_rready) begin
                axi_rvalid <= 1'b0;
            end
        end
    end

    logic [1:0] div;
    logic       pix_en;
    logic [9:0] hc;
    logic [9:0] vc;

    assign pix_en = (div == 2'd3);

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            div <= '0;
            hc  <= '0;
            vc  <= '0;
        end else begin
            div <= div + 2'd1;
            if (pix_en) begin
                if (hc == 10'(H_TOTAL - 1)) begin
                    hc <= '0;
                    vc <= (vc == 10'(V_TOTAL - 1)) ? '0 : vc + 10'd1;
                end else begin
                    hc <= hc + 10'd1;
                end
            end
        end
    end

    logic [11:0] char_idx;
    logic [9:0]  chr_word;
    logic [31:0] chr_data;
    logic [7:0]  chr;
    logic [7:0]  font_data;
    logic        active;
    logic        pix_on;

    assign char_idx = 12'(vc[8:4]) * 12'(COLS) + 12'(hc[9:3]);
    assign chr_word = char_idx[11:2];
    assign chr_data = (chr_word < 10'(VRAM_WORDS)) ? vram[chr_word] : '0;
    assign chr      = chr_data[8*char_idx[1:0] +: 8];
    assign active   = (hc < 10'(H_ACTIVE)) && (vc < 10'(V_ACTIVE));
    assign pix_on   = font_data[3'd7 - hc[2:0]] ^ chr[7];

    hdmi_text_font_rom u_font (
        .addr ({chr[6:0], vc[3:0]}),
        .data (font_data)
    );

    // Colour and sync share one register stage so they leave the block aligned.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
            vde   <= 1'b0;
        end else if (pix_en) begin
            red   <= !active ? '0 : (pix_on ? ctrl.fg_r : ctrl.bg_r);
            green <= !active ? '0 : (pix_on ? ctrl.fg_g : ctrl.bg_g);
            blue  <= !active ? '0 : (pix_on ? ctrl.fg_b : ctrl.bg_b);
            hsync <= !((hc >= 10'(HS_START)) && (hc <= 10'(HS_END)));
            vsync <= !((vc >= 10'(VS_START)) && (vc <= 10'(VS_END)));
            vde   <= active;
        end
    end

`ifdef HDMI_TEXT_DEBUG_EN
    assign pixel_clk_en = pix_en;

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            draw_x <= '0;
            draw_y <= '0;
        end else if (pix_en) begin
            draw_x <= hc;
            draw_y <= vc;
        end
    end
`endif

endmodule

// File: tb/tb_hdmi_text_controller.sv
// Self-checking bench for hdmi_text_controller: register map, handshakes and text rendering.
module tb_hdmi_text_controller;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [3:0]  red, green, blue;
    logic        hsync, vsync, vde;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    hdmi_text_controller #(.C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(16)) dut (
        .axi_aclk(clk), .axi_aresetn(rstn),
        .axi_awaddr(awaddr), .axi_awprot(awprot), .axi_awvalid(awvalid), .axi_awready(awready),
        .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
        .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
        .axi_araddr(araddr), .axi_arprot(arprot), .axi_arvalid(arvalid), .axi_arready(arready),
        .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .vde(vde)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];
    logic [7:0] font_a [16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no response, expected handshake within bound", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (4) tick();
        rstn = 1'b1;
    endtask

    task automatic axi_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit ok;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (awready) begin ok = 1; break; end
        end
        if (!ok) begin
            timeout("awready");
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        check("wready_with_awready", 32'(wready), 32'd1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        ok = 0;
        for (int n = 0; n < 2; n++) begin
            if (bvalid) begin ok = 1; break; end
            tick();
        end
        if (!ok) begin
            timeout("bvalid");
            return;
        end
        check("bresp", 32'(bresp), 32'd0);
        tick();
    endtask

    task automatic axi_read(input logic [15:0] addr, input logic [31:0] exp, input string name);
        bit ok;
        logic [31:0] e;
        exp_q.push_back(exp);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (arready) begin ok = 1; break; end
        end
        arvalid = 1'b0;
        if (!ok) begin
            timeout("arready");
            void'(exp_q.pop_front());
            return;
        end
        tick();
        ok = 0;
        for (int n = 0; n < 3; n++) begin
            if (rvalid) begin ok = 1; break; end
            tick();
        end
        e = exp_q.pop_front();
        if (!ok) begin
            timeout("rvalid");
            return;
        end
        check(name, rdata, e);
        check("rresp", 32'(rresp), 32'd0);
        tick();
    endtask

    initial begin
        int   l0;
        bit   ok;
        logic [7:0]  frow;
        logic [31:0] e;

        vecs[0] = '{16'd2400,  32'h001F6000, 4'b1111, 32'h001F6000};
        vecs[1] = '{16'd0,     32'hAABBCCDD, 4'b1111, 32'hAABBCCDD};
        vecs[2] = '{16'd0,     32'h00001100, 4'b0010, 32'hAABB11DD};
        vecs[3] = '{16'd2404,  32'hDEADBEEF, 4'b1111, 32'h00000000};
        vecs[4] = '{16'd2400,  32'hFFFFFFFF, 4'b0000, 32'h001F6000};
        vecs[5] = '{16'd2396,  32'h12345678, 4'b1001, 32'h12000078};
        vecs[6] = '{16'hFFFC,  32'hFFFFFFFF, 4'b1111, 32'h00000000};
        vecs[7] = '{16'd2400,  32'hFFFFFFFF, 4'b1000, 32'hFF1F6000};

        font_a = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6c, 8'hc6, 8'hc6, 8'hfe,
                   8'hc6, 8'hc6, 8'hc6, 8'hc6, 8'h00, 8'h00, 8'h00, 8'h00};

        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 0; wvalid = 0; arvalid = 0; wdata = '0; wstrb = '0;
        bready = 1; rready = 1;

        do_reset();
        check("rst_handshake", 32'({awready, wready, bvalid, arready, rvalid}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_resp", 32'({bresp, rresp}), 32'd0);
        check("rst_rgb", 32'({red, green, blue}), 32'd0);
        check("rst_sync_vde", 32'({hsync, vsync, vde}), 32'b110);

        for (int i = 0; i < 8; i++) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            axi_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_read", i));
        end

        for (int i = 0; i < 600; i++) axi_write(16'(4 * i), 32'(i), 4'b1111);
        for (int i = 0; i < 600; i++) axi_read(16'(4 * i), 32'(i), $sformatf("vram_%0d", i));

        // bready held low: bvalid must persist and block a second write
        bready = 1'b0;
        awaddr = 16'd8; wdata = 32'h11111111; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (awready) begin ok = 1; break; end
        end
        if (!ok) timeout("bp_awready1");
        tick();
        awaddr = 16'd12; wdata = 32'h22222222;
        for (int n = 0; n < 5; n++) begin
            tick();
            check("bp_bvalid_hold", 32'(bvalid), 32'd1);
            check("bp_no_awready", 32'(awready), 32'd0);
        end
        bready = 1'b1;
        tick();
        check("bp_bvalid_clear", 32'(bvalid), 32'd0);
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (awready) begin ok = 1; break; end
        end
        if (!ok) timeout("bp_awready2");
        tick();
        awvalid = 0; wvalid = 0;
        check("bp_bvalid2", 32'(bvalid), 32'd1);
        tick();
        axi_read(16'd8, 32'h11111111, "bp_first_write");
        axi_read(16'd12, 32'h22222222, "bp_second_write");

        // rready held low: rdata/rvalid must hold
        exp_q.push_back(32'hFF1F6000);
        rready = 1'b0;
        araddr = 16'd2400; arvalid = 1'b1;
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (arready) begin ok = 1; break; end
        end
        if (!ok) timeout("rp_arready");
        tick();
        arvalid = 1'b0;
        e = exp_q.pop_front();
        for (int n = 0; n < 5; n++) begin
            check("rp_rvalid_hold", 32'(rvalid), 32'd1);
            check("rp_rdata_hold", rdata, e);
            tick();
        end
        rready = 1'b1;
        tick();
        check("rp_rvalid_clear", 32'(rvalid), 32'd0);

        // Rendering: first pixel output after reset is (hc=0, vc=0)
        do_reset();
        ok = 0;
        l0 = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (vde) begin ok = 1; l0 = cyc; break; end
        end
        if (!ok) timeout("vde_first_rise");
        axi_write(16'd0, 32'h00000041, 4'hF);
        axi_write(16'd2400, 32'h01FFE000, 4'hF);
        for (int v = 1; v < 16; v++) begin
            frow = font_a[v];
            for (int h = 0; h < 8; h++) begin
                wait_until(l0 + 4 * (v * 800 + h) + 1);
                e = frow[7 - h] ? 32'hFFF : 32'h000;
                check($sformatf("pix_v%0d_h%0d", v, h), 32'({red, green, blue}), e);
                if (h == 0) check($sformatf("vde_line%0d", v), 32'(vde), 32'd1);
            end
            if (v == 1) begin
                wait_until(l0 + 4 * (800 + 639) + 1);
                check("vde_hc639", 32'(vde), 32'd1);
                wait_until(l0 + 4 * (800 + 640) + 1);
                check("vde_hc640", 32'(vde), 32'd0);
                check("rgb_blank_hc640", 32'({red, green, blue}), 32'd0);
                wait_until(l0 + 4 * (800 + 655) + 1);
                check("hsync_hc655", 32'(hsync), 32'd1);
                wait_until(l0 + 4 * (800 + 656) + 1);
                check("hsync_hc656", 32'(hsync), 32'd0);
                wait_until(l0 + 4 * (800 + 751) + 1);
                check("hsync_hc751", 32'(hsync), 32'd0);
                check("vsync_line1", 32'(vsync), 32'd1);
                wait_until(l0 + 4 * (800 + 752) + 1);
                check("hsync_hc752", 32'(hsync), 32'd1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hdmi_text_controller.md
Name: hdmi_text_controller

Overview:
- AXI4-Lite slave holding an 80x30 text-mode VRAM (600 x 32-bit words, 4 chars/word) plus one control register for colours.
- Generates 640x480@60 VGA timing (800x525 total) from the AXI clock via a divide-by-4 pixel enable.
- Renders characters through an 8x16 font ROM; outputs 4-bit RGB with hs/vs/vde to an external TMDS/HDMI encoder.

Parameters:
- C_AXI_DATA_WIDTH, 32, AXI data width; only 32 supported.
- C_AXI_ADDR_WIDTH, 16, AXI byte-address width; word index = addr[C_AXI_ADDR_WIDTH-1:2].

Ports:
- axi_aclk in 1: single clock (100 MHz nominal).
- axi_aresetn in 1: reset, synchronous, active-low.
- axi_awaddr in C_AXI_ADDR_WIDTH: write address. axi_awprot in 3: ignored. axi_awvalid in 1. axi_awready out 1.
- axi_wdata in 32. axi_wstrb in 4: byte enables. axi_wvalid in 1. axi_wready out 1.
- axi_bresp out 2. axi_bvalid out 1. axi_bready in 1.
- axi_araddr in C_AXI_ADDR_WIDTH. axi_arprot in 3: ignored. axi_arvalid in 1. axi_arready out 1.
- axi_rdata out 32. axi_rresp out 2. axi_rvalid out 1. axi_rready in 1.
- red, green, blue out 4 each: pixel colour.
- hsync, vsync out 1 each: active-low syncs.
- vde out 1: active video.

Behaviour:
- Reset (axi_aresetn=0 at a clock edge): all ready/valid outputs 0, bresp/rresp 0, rdata 0, VRAM and control cleared, counters 0, RGB 0, hsync/vsync 1, vde 0.
- Register map (word index):
  - 0..599: VRAM.
  - 600: control. FG R[24:21], FG G[20:17], FG B[16:13], BG R[12:9], BG G[8:5], BG B[4:1]. Other bits are stored and read back unchanged.
  - Index >600: writes ignored; reads return 0.
- Write handshake:
  - When awvalid & wvalid & !bvalid & !awready, pulse awready and wready together for exactly one cycle and commit the write that edge.
  - Each byte lane is written only if its wstrb bit is set.
  - bvalid rises the next cycle with bresp=OKAY(00) and holds until bready is high at an edge.
  - A new write is not accepted while bvalid is high.
- Read handshake:
  - When arvalid & !rvalid & !arready, pulse arready for one cycle and latch the address.
  - Next cycle: rvalid=1, rdata=register, rresp=00. rdata and rvalid hold until rready is high at an edge.
  - Read-after-write to the same address returns the new data.
  - Simultaneous read and write to different addresses are both serviced independently.
- Timing generator:
  - pix_en is high every 4th axi_aclk.
  - hc 0..799 and vc 0..524 advance on pix_en; vc increments when hc wraps at 799 and itself wraps at 524.
  - hsync low for hc 656..751; vsync low for vc 490..491; vde = (hc<640)&(vc<480).
- Rendering:
  - col = hc[9:3], row = vc[8:4], idx = row*80+col, word = idx>>2, byte = idx[1:0] (byte 0 = bits[7:0]).
  - Char byte: bit7 = invert, bits6:0 = code.
  - font_rom address = {code, vc[3:0]}; pixel bit = data[7-hc[2:0]].
  - on = bit ^ invert; RGB = on ? FG : BG.
  - RGB = 0 when !vde.
  - RGB, hs, vs and vde are registered on pix_en with identical latency so they stay aligned.
- Control or VRAM writes take effect on the next rendered pixel that reads them; no frame buffering.

Optional Feature:
- HDMI_TEXT_DEBUG_EN defined: adds outputs draw_x[9:0] (hc), draw_y[9:0] (vc) and pixel_clk_en (pix_en), aligned with RGB, for simulation image capture.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package hdmi_text_pkg holds:
  - Timing constants: H_ACTIVE=640, H_TOTAL=800, HS_START=656, HS_END=751, V_ACTIVE=480, V_TOTAL=525, VS_START=490, VS_END=491.
  - Text constants: COLS=80, ROWS=30, VRAM_WORDS=600, CTRL_IDX=600.
  - A typedef for the control-register fields.
- One sub-module, hdmi_text_font_rom: 2048x8 combinational ROM, standard 8x16 IBM font.

Test Plan:
- Reset 4 cycles, then write 0x001F6000 to byte address 2400 -> bvalid within 2 cycles, bresp=00; readback of 2400 = 0x001F6000.
- Write i to byte address 4*i for i=0..599, then read all -> each read returns i, rresp=00.
- Write 0xAABBCCDD to address 0, then wstrb=0010 with data 0x00001100 -> readback 0xAABB11DD.
- Read byte address 2404 -> 0; a write to 2404 gets bresp=00 and changes no register.
- Hold bready low 5 cycles after a write -> bvalid stays 1 and no new awready until bready is accepted. Hold rready low -> rdata stable.
- VRAM word 0 = 0x00000041, control FG=white (0x01FFE000) -> at vc=0..15, hc=0..7 pixels match font 'A' rows in white; hsync low exactly hc 656..751; one frame = 800*525*4 clocks.
